// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; master drives operands, slave is the adder.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_cout,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_cout,
    output busy
  );

endinterface

// File: rtl/full_add_cell.sv
// One-bit combinational full adder used for each serial step.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ cin;
    co = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH RUN cycles per operation, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_SAT_EN to saturate out_sum to all ones when the final carry is set.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic          clk,
  input  logic          rstn,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              bit_s;
  logic              bit_co;
  logic              accept;

  full_add_cell u_cell (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (bit_s),
    .co  (bit_co)
  );

  // in_ready is gated by rstn directly so it drops the instant reset asserts.
  assign bus.in_ready  = (state_q == StIdle) && rstn;
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StRun) || (state_q == StDone);
  assign bus.out_cout  = carry_q;
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef SERIAL_ADDER_SAT_EN
  assign bus.out_sum = carry_q ? {WIDTH{1'b1}} : sum_q;
`else
  assign bus.out_sum = sum_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        carry_d = bit_co;
        // Hold the counter on the last bit so it never wraps inside an operation.
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8, including reset and backpressure sequences.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_sum(input logic [7:0] raw, input logic cout);
`ifdef SERIAL_ADDER_SAT_EN
    return cout ? 8'hFF : raw;
`else
    return raw;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, wait for the result, check it, then drain it.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] e_sum, input logic e_cout);
    int lat;
    check({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = 8'($urandom);
    bus.in_b     = 8'($urandom);
    bus.in_cin   = 1'($urandom);
    check({tag, " busy after accept"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " out_sum"}, 32'(bus.out_sum), 32'(e_sum));
    check({tag, " out_cout"}, 32'(bus.out_cout), 32'(e_cout));
    check({tag, " in_ready in DONE"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " idle after drain"}, {30'd0, bus.out_valid, bus.busy}, 32'd0);
  endtask

  initial begin
    int seen;
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3]  = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
    vecs[4]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6]  = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};
    vecs[8]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[10] = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1};

    // Reset held for 3 cycles with in_valid asserted.
    rstn          = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'h5A;
    bus.in_b      = 8'hA5;
    bus.in_cin    = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset outputs", {21'd0, bus.out_valid, bus.out_sum, bus.out_cout, bus.busy,
                              bus.in_ready}, 32'd0);
      tick();
    end
    rstn = 1'b1;
    #1;
    check("in_ready after release", 32'(bus.in_ready), 32'd1);
    check("busy after release", 32'(bus.busy), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    check("no op started after release", {30'd0, bus.busy, bus.out_valid}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             exp_sum(vecs[i].sum, vecs[i].cout), vecs[i].cout);
    end

    // Backpressure: hold the result for 10 cycles while offering a new operand.
    bus.in_valid = 1'b1;
    bus.in_a     = 8'h0F;
    bus.in_b     = 8'h01;
    bus.in_cin   = 1'b0;
    tick();
    bus.in_a = 8'h33;
    bus.in_b = 8'h44;
    seen = 0;
    while (!bus.out_valid && seen < 50) begin
      tick();
      seen++;
    end
    check("bp latency", 32'(seen), 32'd8);
    for (int i = 0; i < 10; i++) begin
      check("bp hold", {22'd0, bus.out_valid, bus.in_ready, bus.out_sum},
            {22'd0, 1'b1, 1'b0, 8'h10});
      tick();
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    check("bp drained", {29'd0, bus.out_valid, bus.busy, bus.in_ready}, 32'd1);
    tick();
    check("bp no second op", 32'(bus.busy), 32'd0);

    // Reset pulsed mid-RUN discards the operation.
    bus.in_valid = 1'b1;
    bus.in_a     = 8'h55;
    bus.in_b     = 8'h22;
    bus.in_cin   = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("busy mid-run", 32'(bus.busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("busy in reset", {30'd0, bus.busy, bus.out_valid}, 32'd0);
    tick();
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid || bus.busy) seen++;
    end
    bus.out_ready = 1'b0;
    check("aborted op silent", 32'(seen), 32'd0);
    run_op("post-reset", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
